add_seq_n: RTL and testbench

Multi-cycle, parametrised adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock through one reused CHUNK-bit adder slice. It is the sequential successor to the combinational 1-/4-bit full adders. It trades latency for area on wide datapaths and adds subtract mode, signed-overflow detection and a start/busy/done handshake. It sits between operand registers and any consumer that can tolerate WIDTH/CHUNK cycles of latency.

---
 rtl/add_pkg.sv | 27 ++
 rtl/add_chunk_n.sv | 28 ++
 rtl/add_seq_n.sv | 128 ++++++++++++
 tb/tb_add_seq_n.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor.
// State encodings and helpers that size the chunk index from WIDTH/CHUNK.
package add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit so a single-slice build still has a counter.
  function automatic int idx_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_chunk_n.sv
// Combinational W-bit ripple adder slice, reused once per cycle by add_seq_n.
// cm is the carry into the top bit so the caller can form signed overflow.
module add_chunk_n #(
  parameter int W = 4
) (
  output logic         co,
  output logic         cm,
  output logic [W-1:0] s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci
);

  // Ripple the carry bit by bit, capturing the carry entering the MSB.
  always_comb begin : ripple
    logic c;
    c  = ci;
    s  = '0;
    cm = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cm = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq_n.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock through one slice.
// Optional build macro: ADD_SEQ_SAT_EN clamps s to the signed limit on overflow.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one slice per cycle, idx selects the slice, carry is registered
// DONE  | one-cycle done pulse; a new start is accepted here as in IDLE
module add_seq_n
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             v
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(WIDTH, CHUNK);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q, v_q;
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_co, slice_cm, ovf;

  assign last    = (idx_q == IDX_LAST);
  assign slice_a = a_q[idx_q * CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q * CHUNK +: CHUNK];
  assign ovf     = slice_cm ^ slice_co;

  add_chunk_n #(.W(CHUNK)) u_chunk (
    .co (slice_co),
    .cm (slice_cm),
    .s  (slice_s),
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q)
  );

  // Next-state and handshake outputs; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture (subtract folded in as ~b, ~ci), slice write-back and final flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~ci : ci;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      s_q[idx_q * CHUNK +: CHUNK] <= slice_s;
      carry_q <= slice_co;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        co_q <= slice_co;
        v_q  <= ovf;
`ifdef ADD_SEQ_SAT_EN
        // Clamp in the same edge as the last slice; the whole word overrides the slice write.
        if (ovf) s_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

  assign s  = s_q;
  assign co = co_q;
  assign v  = v_q;

endmodule

// File: tb/tb_add_seq_n.sv
// Self-checking bench for add_seq_n (WIDTH=16, CHUNK=4) with a result scoreboard.
module tb_add_seq_n;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             v;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n, start, sub, ci;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, co, v;
  logic [WIDTH-1:0] s;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  add_seq_n #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .v(v)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mci, input logic msub);
    res_t r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, msub ? ~mci : mci};
    r.s  = full[WIDTH-1:0];
    r.co = full[WIDTH];
    r.v  = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`ifdef ADD_SEQ_SAT_EN
    if (r.v) r.s = ma[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  // Called at a negedge: present an operation and record its expected result.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tci, input logic tsub);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    sb.push_back(model(ta, tb, tci, tsub));
  endtask

  // Drops start after the accepting edge and waits (bounded) for done.
  task automatic wait_done(output int lat, output int busy_cnt, output int overlap);
    lat = -1; busy_cnt = 0; overlap = 0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      if (busy && done) overlap++;
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, s, co, v} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b s=%h co=%b v=%b, required all zero", busy, done, s, co, v);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith(input logic do_sub);
    logic [WIDTH-1:0] ta[8];
    logic [WIDTH-1:0] tb[8];
    logic             tc[8];
    int               lat, bc, ov;
    res_t             exp;
    if (!do_sub) begin
      ta[0] = 16'h0005; tb[0] = 16'h000A; tc[0] = 1'b0;
      ta[1] = 16'hFFFF; tb[1] = 16'h0001; tc[1] = 1'b1;
      ta[2] = 16'h7FFF; tb[2] = 16'h0001; tc[2] = 1'b0;
      ta[3] = 16'h8000; tb[3] = 16'h8000; tc[3] = 1'b0;
    end else begin
      ta[0] = 16'h0003; tb[0] = 16'h0005; tc[0] = 1'b0;
      ta[1] = 16'h8000; tb[1] = 16'h0001; tc[1] = 1'b0;
      ta[2] = 16'h1234; tb[2] = 16'h1234; tc[2] = 1'b1;
      ta[3] = 16'h7FFF; tb[3] = 16'hFFFF; tc[3] = 1'b0;
    end
    for (int i = 4; i < 8; i++) begin
      ta[i] = WIDTH'($urandom);
      tb[i] = WIDTH'($urandom);
      tc[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      start_op(ta[i], tb[i], tc[i], do_sub);
      wait_done(lat, bc, ov);
      checks++;
      if (lat != NCHUNK || bc != NCHUNK || ov != 0) begin
        errors++;
        $display("FAIL timing sub=%b #%0d: latency=%0d busy_cycles=%0d overlap=%0d, required %0d/%0d/0",
                 do_sub, i, lat, bc, ov, NCHUNK, NCHUNK);
      end
      exp = sb.pop_front();
      checks++;
      if ({s, co, v} !== exp) begin
        errors++;
        $display("FAIL result sub=%b a=%h b=%h ci=%b: got s=%h co=%b v=%b, required s=%h co=%b v=%b",
                 do_sub, ta[i], tb[i], tc[i], s, co, v, exp.s, exp.co, exp.v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_during_run();
    int   j;
    res_t exp;
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; ci = 1'b1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 2;
    while (!done && j < 20) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (!done || j != NCHUNK) begin
      errors++;
      $display("FAIL start_in_run latency: got %0d (done=%b), required %0d", j, done, NCHUNK);
    end
    exp = sb.pop_front();
    checks++;
    if ({s, co, v} !== exp) begin
      errors++;
      $display("FAIL start_in_run result: got s=%h co=%b v=%b, required s=%h co=%b v=%b",
               s, co, v, exp.s, exp.co, exp.v);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run idle: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int   j;
    res_t exp;
    start_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
    @(negedge clk);
    start_op(16'h4000, 16'h0123, 1'b0, 1'b1);
    j = 0;
    while (!done && j < 20) begin
      @(negedge clk);
      j++;
    end
    exp = sb.pop_front();
    checks++;
    if (!done || j != NCHUNK || {s, co, v} !== exp) begin
      errors++;
      $display("FAIL b2b first: lat=%0d s=%h co=%b v=%b, required lat=%0d s=%h co=%b v=%b",
               j, s, co, v, NCHUNK, exp.s, exp.co, exp.v);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b accept: done=%b busy=%b, required 0/1", done, busy);
    end
    j = 0;
    while (!done && j < 20) begin
      @(negedge clk);
      j++;
    end
    exp = sb.pop_front();
    checks++;
    if (!done || j != NCHUNK || {s, co, v} !== exp) begin
      errors++;
      $display("FAIL b2b second: lat=%0d s=%h co=%b v=%b, required lat=%0d s=%h co=%b v=%b",
               j, s, co, v, NCHUNK, exp.s, exp.co, exp.v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, s, co, v} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b s=%h co=%b v=%b, required all zero", busy, done, s, co, v);
    end
    rst_n = 1'b1;
    sb.delete();
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_run done pulses: got %0d, required 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_arith(1'b0);
    test_arith(1'b1);
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
